fetch_unit: RTL

//  Instruction fetch stage feeding decode. Holds the PC and drives the two read

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, drives the two read addresses of a
//   dual-port instruction memory (pc and pc+4), captures up to two words per
//   cycle into a small prefetch queue, and hands them to decode one per cycle
//   over a valid/ready handshake. A redirect flushes the queue and reloads the
//   PC. Fetch stops at the end of the memory image until the next redirect.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_addr1/2      byte addresses to memory ports (pc, pc+4)
//   imem_data1/2      combinational read data for those addresses
//   redirect_valid    flush queue and load redirect_pc (word aligned)
//   redirect_pc       redirect target; bits [1:0] ignored
//   inst_valid        queue head valid
//   inst_ready        decode accepts the head this cycle
//   inst, inst_pc     head instruction and its byte address (0 when empty)
//   q_count           queue occupancy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 56
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_addr1,
  output logic [31:0]                imem_addr2,
  input  logic [31:0]                imem_data1,
  input  logic [31:0]                imem_data2,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      LIMIT   = 32'(MEM_WORDS * 4);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // State
  logic [31:0]      pc_q,     pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Queue storage
  logic [31:0] q_pc_mem   [DEPTH];
  logic [31:0] q_inst_mem [DEPTH];

  // Datapath
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] free;
  logic             push1, push2, pop;
  logic [1:0]       n_push;
  logic [PTR_W-1:0] wr_ptr_p1;

  // The two low bits of the redirect target are dropped by design.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_plus4   = pc_q + 32'd4;
  // Room is judged on occupancy at cycle start; a same-cycle pop adds nothing.
  assign free       = DEPTH_C - count_q;
  assign pop        = (count_q != '0) && inst_ready;
  assign n_push     = {1'b0, push1} + {1'b0, push2};
  assign wr_ptr_p1  = wr_ptr_q + PTR_W'(1);

  assign imem_addr1 = pc_q;
  assign imem_addr2 = pc_plus4;

  // Push decision: the second word is taken only when there is room for two
  // and pc+4 is still inside the image. At or past the limit fetch stalls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    push1 = 1'b0;
    push2 = 1'b0;
    if (!redirect_valid && (pc_q < LIMIT) && (free != '0)) begin
      push1 = 1'b1;
      if ((free >= CNT_W'(2)) && (pc_plus4 < LIMIT)) push2 = 1'b1;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // Flush wins over any push or pop in the same cycle.
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push2)      pc_d = pc_q + 32'd8;
      else if (push1) pc_d = pc_plus4;
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is not reset; entries are only visible through
  // count_q, which is reset, so stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (push1) begin
      q_pc_mem[wr_ptr_q]   <= pc_q;
      q_inst_mem[wr_ptr_q] <= imem_data1;
    end
    if (push2) begin
      q_pc_mem[wr_ptr_p1]   <= pc_plus4;
      q_inst_mem[wr_ptr_p1] <= imem_data2;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? q_inst_mem[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? q_pc_mem[rd_ptr_q]   : 32'd0;
  assign q_count    = count_q;

endmodule
